// File: rtl/jtdd_snd_rom_arb_if.sv
// rtl/jtdd_snd_rom_arb_if.sv - shared ROM/SDRAM read port bundle
interface jtdd_snd_rom_arb_if #(
  parameter int AW = 18
);
  logic [AW-1:0] addr;
  logic          cs;
  logic [7:0]    data;
  logic          ok;

  modport master (output addr, output cs, input data, input ok);
  modport slave  (input addr, input cs, output data, output ok);
endinterface

// File: rtl/jtdd_snd_rom_arb.sv
// rtl/jtdd_snd_rom_arb.sv - sound ROM arbiter, CPU + 2 ADPCM clients, optional watchdog JTDD_ARB_TIMEOUT_EN
module jtdd_snd_rom_arb #(
  parameter int            AW      = 18,
  parameter logic [AW-1:0] CPU_OFS = 18'h00000,
  parameter logic [AW-1:0] AD0_OFS = 18'h08000,
  parameter logic [AW-1:0] AD1_OFS = 18'h18000,
  parameter logic [7:0]    TOUT    = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cs,
  input  logic [14:0]       cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_ok,
  input  logic              ad0_cs,
  input  logic [15:0]       ad0_addr,
  output logic [7:0]        ad0_data,
  output logic              ad0_ok,
  input  logic              ad1_cs,
  input  logic [15:0]       ad1_addr,
  output logic [7:0]        ad1_data,
  output logic              ad1_ok,
  jtdd_snd_rom_arb_if.master rom,
  output logic              busy
`ifdef JTDD_ARB_TIMEOUT_EN
  ,
  output logic              tout_flag
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;
  typedef enum logic [1:0] {G_CPU = 2'd0, G_AD0 = 2'd1, G_AD1 = 2'd2} gnt_t;

  state_t        state_q, state_d;
  gnt_t          gnt_q, gnt_d, win;
  logic          rr_q, rr_d;            // 0: ADPCM0 next on a tie, 1: ADPCM1 next
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          busy_q, busy_d;
  logic [14:0]   cpu_tag_q, cpu_tag_d;
  logic [15:0]   ad0_tag_q, ad0_tag_d;
  logic [15:0]   ad1_tag_q, ad1_tag_d;
  logic [7:0]    cpu_data_q, cpu_data_d;
  logic [7:0]    ad0_data_q, ad0_data_d;
  logic [7:0]    ad1_data_q, ad1_data_d;
  logic          cpu_valid_q, cpu_valid_d;
  logic          ad0_valid_q, ad0_valid_d;
  logic          ad1_valid_q, ad1_valid_d;
  logic          fill;
  logic [7:0]    fill_data;
`ifdef JTDD_ARB_TIMEOUT_EN
  logic [7:0]    cnt_q, cnt_d;
  logic          tout_q, tout_d;
`else
  logic          unused_tout;
  // The watchdog limit has no effect without the watchdog
  assign unused_tout = ^TOUT;
`endif

  logic cpu_hit, ad0_hit, ad1_hit;
  logic cpu_miss, ad0_miss, ad1_miss, any_miss;
  logic [AW-1:0] cpu_ext, ad0_ext, ad1_ext;

  assign cpu_ext = AW'(cpu_addr);
  assign ad0_ext = AW'(ad0_addr);
  assign ad1_ext = AW'(ad1_addr);

  // ok follows the address combinationally so it drops the cycle the address moves
  assign cpu_hit  = cpu_cs & cpu_valid_q & (cpu_addr == cpu_tag_q);
  assign ad0_hit  = ad0_cs & ad0_valid_q & (ad0_addr == ad0_tag_q);
  assign ad1_hit  = ad1_cs & ad1_valid_q & (ad1_addr == ad1_tag_q);
  assign cpu_miss = cpu_cs & ~cpu_hit;
  assign ad0_miss = ad0_cs & ~ad0_hit;
  assign ad1_miss = ad1_cs & ~ad1_hit;
  assign any_miss = cpu_miss | ad0_miss | ad1_miss;

  assign cpu_ok   = cpu_hit;
  assign ad0_ok   = ad0_hit;
  assign ad1_ok   = ad1_hit;
  assign cpu_data = cpu_data_q;
  assign ad0_data = ad0_data_q;
  assign ad1_data = ad1_data_q;
  assign rom.cs   = rom_cs_q;
  assign rom.addr = rom_addr_q;
  assign busy     = busy_q;
`ifdef JTDD_ARB_TIMEOUT_EN
  assign tout_flag = tout_q;
`endif

  // Winner selection: CPU first, ADPCM channels alternate on a tie
  always_comb begin
    win = G_CPU;
    if (cpu_miss)                 win = G_CPU;
    else if (ad0_miss && ad1_miss) win = rr_q ? G_AD1 : G_AD0;
    else if (ad0_miss)            win = G_AD0;
    else if (ad1_miss)            win = G_AD1;
  end

  // Fetch sequencer and cache update
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    rom_cs_d    = rom_cs_q;
    rom_addr_d  = rom_addr_q;
    busy_d      = busy_q;
    cpu_tag_d   = cpu_tag_q;
    ad0_tag_d   = ad0_tag_q;
    ad1_tag_d   = ad1_tag_q;
    cpu_data_d  = cpu_data_q;
    ad0_data_d  = ad0_data_q;
    ad1_data_d  = ad1_data_q;
    cpu_valid_d = cpu_valid_q;
    ad0_valid_d = ad0_valid_q;
    ad1_valid_d = ad1_valid_q;
    fill        = 1'b0;
    fill_data   = rom.data;
`ifdef JTDD_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    tout_d      = tout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_miss) begin
          state_d  = S_ISSUE;
          rom_cs_d = 1'b1;
          busy_d   = 1'b1;
          gnt_d    = win;
          case (win)
            G_CPU: begin
              rom_addr_d  = CPU_OFS + cpu_ext;
              cpu_tag_d   = cpu_addr;
              cpu_valid_d = 1'b0;
            end
            G_AD0: begin
              rom_addr_d  = AD0_OFS + ad0_ext;
              ad0_tag_d   = ad0_addr;
              ad0_valid_d = 1'b0;
              rr_d        = 1'b1;
            end
            default: begin
              rom_addr_d  = AD1_OFS + ad1_ext;
              ad1_tag_d   = ad1_addr;
              ad1_valid_d = 1'b0;
              rr_d        = 1'b0;
            end
          endcase
`ifdef JTDD_ARB_TIMEOUT_EN
          cnt_d = 8'd0;
`endif
        end
      end
      S_ISSUE: begin
        // A lingering ok from the previous fetch is discarded here
        state_d = S_WAIT;
`ifdef JTDD_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
      end
      S_WAIT: begin
        if (rom.ok) fill = 1'b1;
`ifdef JTDD_ARB_TIMEOUT_EN
        else if (cnt_q >= TOUT) begin
          fill      = 1'b1;
          fill_data = 8'hFF;
          tout_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (fill) begin
      state_d  = S_IDLE;
      rom_cs_d = 1'b0;
      busy_d   = 1'b0;
      case (gnt_q)
        G_CPU: begin
          cpu_data_d  = fill_data;
          cpu_valid_d = 1'b1;
        end
        G_AD0: begin
          ad0_data_d  = fill_data;
          ad0_valid_d = 1'b1;
        end
        default: begin
          ad1_data_d  = fill_data;
          ad1_valid_d = 1'b1;
        end
      endcase
    end
  end

  // State and cache registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= G_CPU;
      rr_q        <= 1'b0;
      rom_cs_q    <= 1'b0;
      rom_addr_q  <= '0;
      busy_q      <= 1'b0;
      cpu_tag_q   <= '0;
      ad0_tag_q   <= '0;
      ad1_tag_q   <= '0;
      cpu_data_q  <= '0;
      ad0_data_q  <= '0;
      ad1_data_q  <= '0;
      cpu_valid_q <= 1'b0;
      ad0_valid_q <= 1'b0;
      ad1_valid_q <= 1'b0;
`ifdef JTDD_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      tout_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      rom_cs_q    <= rom_cs_d;
      rom_addr_q  <= rom_addr_d;
      busy_q      <= busy_d;
      cpu_tag_q   <= cpu_tag_d;
      ad0_tag_q   <= ad0_tag_d;
      ad1_tag_q   <= ad1_tag_d;
      cpu_data_q  <= cpu_data_d;
      ad0_data_q  <= ad0_data_d;
      ad1_data_q  <= ad1_data_d;
      cpu_valid_q <= cpu_valid_d;
      ad0_valid_q <= ad0_valid_d;
      ad1_valid_q <= ad1_valid_d;
`ifdef JTDD_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      tout_q      <= tout_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtdd_snd_rom_arb.sv
// tb/tb_jtdd_snd_rom_arb.sv - randomized self-checking bench for jtdd_snd_rom_arb
module tb_jtdd_snd_rom_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cpu_cs, ad0_cs, ad1_cs;
  logic [14:0] cpu_addr;
  logic [15:0] ad0_addr, ad1_addr;
  logic [7:0]  cpu_data, ad0_data, ad1_data;
  logic        cpu_ok, ad0_ok, ad1_ok;
  logic        busy;
`ifdef JTDD_ARB_TIMEOUT_EN
  logic        tout_flag;
`endif

  int checks = 0;
  int failures = 0;

  jtdd_snd_rom_arb_if #(.AW(18)) rom_bus ();

  jtdd_snd_rom_arb #(.AW(18), .TOUT(8'd16)) dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
    .ad0_cs(ad0_cs), .ad0_addr(ad0_addr), .ad0_data(ad0_data), .ad0_ok(ad0_ok),
    .ad1_cs(ad1_cs), .ad1_addr(ad1_addr), .ad1_data(ad1_data), .ad1_ok(ad1_ok),
    .rom(rom_bus.master),
    .busy(busy)
`ifdef JTDD_ARB_TIMEOUT_EN
    , .tout_flag(tout_flag)
`endif
  );

  // Memory contents: a fixed scramble of the 18-bit address
  function automatic logic [7:0] mem_f(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h7C;
  endfunction

  logic [17:0] ofs_a [3] = '{18'h00000, 18'h08000, 18'h18000};

  // Memory model: answers lat_cfg cycles after the first cycle it sees cs
  int   lat_cfg  = 0;
  int   lat_cnt  = 0;
  logic mem_dead = 1'b0;
  always @(posedge clk) begin
    if (rom_bus.cs !== 1'b1) begin
      rom_bus.ok   <= 1'b0;
      rom_bus.data <= 8'h00;
      lat_cnt      <= lat_cfg;
    end else if (mem_dead) begin
      rom_bus.ok <= 1'b0;
    end else if (lat_cnt == 0) begin
      rom_bus.ok   <= 1'b1;
      rom_bus.data <= mem_f(rom_bus.addr);
    end else begin
      rom_bus.ok <= 1'b0;
      lat_cnt    <= lat_cnt - 1;
    end
  end

  // Bus monitor: logs every fetch address and counts missing idle gaps
  logic        prev_cs = 1'b0;
  logic        prev_done = 1'b0;
  int          gap_err = 0;
  logic [17:0] grant_q [$];
  always @(negedge clk) begin
    if (rom_bus.cs === 1'b1 && !prev_cs) grant_q.push_back(rom_bus.addr);
    if (prev_done && rom_bus.cs === 1'b1) gap_err <= gap_err + 1;
    prev_done <= (rom_bus.cs === 1'b1) && (rom_bus.ok === 1'b1);
    prev_cs   <= (rom_bus.cs === 1'b1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_cs = 0; ad0_cs = 0; ad1_cs = 0;
    cpu_addr = 0; ad0_addr = 0; ad1_addr = 0;
    step(); step();
    checks++;
    if ({rom_bus.cs, busy, cpu_ok, ad0_ok, ad1_ok} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {rom_bus.cs, busy, cpu_ok, ad0_ok, ad1_ok});
    end
    checks++;
    if (rom_bus.addr !== 18'h0) begin
      failures++; $display("FAIL reset_addr got=%h exp=0", rom_bus.addr);
    end
    checks++;
    if ({cpu_data, ad0_data, ad1_data} !== 24'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {cpu_data, ad0_data, ad1_data});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_cpu_basic();
    lat_cfg = 0;
    grant_q.delete();
    cpu_cs = 1; cpu_addr = 15'h1234;
    step();
    checks++;
    if ({rom_bus.cs, busy} !== 2'b11 || rom_bus.addr !== 18'h01234) begin
      failures++; $display("FAIL cpu_issue cs_busy=%b addr=%h exp cs_busy=11 addr=01234", {rom_bus.cs, busy}, rom_bus.addr);
    end
    step();
    checks++;
    if (cpu_ok !== 1'b0) begin
      failures++; $display("FAIL cpu_early_ok got=%b exp=0", cpu_ok);
    end
    step();
    checks++;
    if (cpu_ok !== 1'b1 || cpu_data !== 8'h5A) begin
      failures++; $display("FAIL cpu_latency ok=%b data=%h exp ok=1 data=5a", cpu_ok, cpu_data);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (cpu_ok !== 1'b1) begin
        failures++; $display("FAIL cpu_hold_ok cycle=%0d got=%b exp=1", i, cpu_ok);
      end
    end
    checks++;
    if (grant_q.size() != 1) begin
      failures++; $display("FAIL cpu_single_fetch got=%0d fetches exp=1", grant_q.size());
    end
  endtask

  task automatic test_adpcm_pair();
    int g0;
    int n;
    g0 = gap_err;
    grant_q.delete();
    cpu_cs = 0;
    ad0_cs = 1; ad0_addr = 16'h0010;
    ad1_cs = 1; ad1_addr = 16'h0020;
    n = 0;
    while (!(ad0_ok === 1'b1 && ad1_ok === 1'b1) && n < 40) begin step(); n++; end
    checks++;
    if (n >= 40) begin
      failures++; $display("FAIL pair_timeout ok=%b%b exp=11", ad0_ok, ad1_ok);
    end
    checks++;
    if (grant_q.size() != 2) begin
      failures++; $display("FAIL pair_count got=%0d exp=2", grant_q.size());
    end else if (grant_q[0] !== 18'h08010 || grant_q[1] !== 18'h18020) begin
      failures++; $display("FAIL pair_order got=%h,%h exp=08010,18020", grant_q[0], grant_q[1]);
    end
    checks++;
    if (ad0_data !== mem_f(18'h08010) || ad1_data !== mem_f(18'h18020)) begin
      failures++; $display("FAIL pair_data got=%h,%h exp=%h,%h", ad0_data, ad1_data, mem_f(18'h08010), mem_f(18'h18020));
    end
    checks++;
    if (gap_err != g0) begin
      failures++; $display("FAIL pair_gap got=%0d exp=%0d", gap_err, g0);
    end
  endtask

  task automatic test_cpu_preempt();
    int n;
    lat_cfg = 3;
    grant_q.delete();
    ad0_addr = 16'h0030;
    ad1_addr = 16'h0040;
    step(); step();
    checks++;
    if (rom_bus.cs !== 1'b1 || rom_bus.addr !== 18'h08030) begin
      failures++; $display("FAIL preempt_ad0_busy cs=%b addr=%h exp cs=1 addr=08030", rom_bus.cs, rom_bus.addr);
    end
    cpu_cs = 1; cpu_addr = 15'h0500;
    n = 0;
    while (!(cpu_ok === 1'b1 && ad0_ok === 1'b1 && ad1_ok === 1'b1) && n < 60) begin step(); n++; end
    checks++;
    if (grant_q.size() != 3) begin
      failures++; $display("FAIL preempt_count got=%0d exp=3", grant_q.size());
    end else if (grant_q[0] !== 18'h08030 || grant_q[1] !== 18'h00500 || grant_q[2] !== 18'h18040) begin
      failures++; $display("FAIL preempt_order got=%h,%h,%h exp=08030,00500,18040", grant_q[0], grant_q[1], grant_q[2]);
    end
    checks++;
    if (cpu_data !== mem_f(18'h00500)) begin
      failures++; $display("FAIL preempt_cpu_data got=%h exp=%h", cpu_data, mem_f(18'h00500));
    end
  endtask

  task automatic test_midfetch();
    int n;
    int early;
    lat_cfg = 3;
    cpu_cs = 0; ad0_cs = 0;
    grant_q.delete();
    ad1_addr = 16'h0100;
    n = 0;
    while (rom_bus.cs !== 1'b1 && n < 10) begin step(); n++; end
    ad1_addr = 16'h0101;
    early = 0;
    n = 0;
    while (ad1_ok !== 1'b1 && n < 40) begin
      step(); n++;
      if (ad1_ok === 1'b1 && grant_q.size() < 2) early++;
    end
    checks++;
    if (early != 0 || n >= 40) begin
      failures++; $display("FAIL mid_stale_ok early=%0d wait=%0d exp early=0", early, n);
    end
    checks++;
    if (grant_q.size() != 2) begin
      failures++; $display("FAIL mid_count got=%0d exp=2", grant_q.size());
    end else if (grant_q[0] !== 18'h18100 || grant_q[1] !== 18'h18101) begin
      failures++; $display("FAIL mid_order got=%h,%h exp=18100,18101", grant_q[0], grant_q[1]);
    end
    checks++;
    if (ad1_data !== mem_f(18'h18101)) begin
      failures++; $display("FAIL mid_data got=%h exp=%h", ad1_data, mem_f(18'h18101));
    end
    ad1_addr = 16'h0100;
    #1;
    checks++;
    if (ad1_ok !== 1'b0) begin
      failures++; $display("FAIL mid_back_no_hit got=%b exp=0", ad1_ok);
    end
    n = 0;
    while (ad1_ok !== 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (grant_q.size() != 3 || ad1_data !== mem_f(18'h18100)) begin
      failures++; $display("FAIL mid_refetch fetches=%0d data=%h exp 3,%h", grant_q.size(), ad1_data, mem_f(18'h18100));
    end
  endtask

  task automatic test_reset_wait();
    int n;
    lat_cfg = 20;
    ad1_cs = 0;
    cpu_cs = 1; cpu_addr = 15'h0500;
    ad0_cs = 1; ad0_addr = 16'h0777;
    n = 0;
    while (rom_bus.cs !== 1'b1 && n < 10) begin step(); n++; end
    step(); step(); step();
    checks++;
    if (cpu_ok !== 1'b1 || rom_bus.cs !== 1'b1) begin
      failures++; $display("FAIL rstw_pre cpu_ok=%b cs=%b exp 1,1", cpu_ok, rom_bus.cs);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rom_bus.cs, busy, cpu_ok, ad0_ok, ad1_ok} !== 5'b0) begin
      failures++; $display("FAIL rstw_async got=%b exp=00000", {rom_bus.cs, busy, cpu_ok, ad0_ok, ad1_ok});
    end
    step();
    lat_cfg = 0;
    grant_q.delete();
    rst = 1'b0;
    n = 0;
    while (!(cpu_ok === 1'b1 && ad0_ok === 1'b1) && n < 30) begin step(); n++; end
    checks++;
    if (grant_q.size() != 2) begin
      failures++; $display("FAIL rstw_refetch_count got=%0d exp=2", grant_q.size());
    end else if (grant_q[0] !== 18'h00500 || grant_q[1] !== 18'h08777) begin
      failures++; $display("FAIL rstw_refetch got=%h,%h exp=00500,08777", grant_q[0], grant_q[1]);
    end
  endtask

`ifdef JTDD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    checks++;
    if (tout_flag !== 1'b0) begin
      failures++; $display("FAIL tout_flag_initial got=%b exp=0", tout_flag);
    end
    mem_dead = 1'b1;
    cpu_cs = 0; ad1_cs = 0;
    ad0_cs = 1; ad0_addr = 16'h0ABC;
    n = 0;
    while (rom_bus.cs !== 1'b1 && n < 10) begin step(); n++; end
    n = 0;
    while (ad0_ok !== 1'b1 && n < 60) begin step(); n++; end
    checks++;
    if (n < 16 || n > 18) begin
      failures++; $display("FAIL tout_latency got=%0d exp=16..18", n);
    end
    checks++;
    if (ad0_data !== 8'hFF || tout_flag !== 1'b1) begin
      failures++; $display("FAIL tout_result data=%h flag=%b exp ff,1", ad0_data, tout_flag);
    end
    mem_dead = 1'b0;
    step(); step();
  endtask
`endif

  task automatic test_random();
    logic [15:0] a_v [3];
    logic        c_v [3];
    logic        k_v [3];
    logic [7:0]  d_v [3];
    logic [15:0] pa [3];
    logic        pc [3];
    logic        pk [3];
    int          stall [3];
    int          max_stall [3];
    logic [17:0] ea;
    int          g0;
    g0 = gap_err;
    for (int c = 0; c < 3; c++) begin pk[c] = 0; pc[c] = 0; pa[c] = 0; stall[c] = 0; max_stall[c] = 0; end
    cpu_cs = 1; ad0_cs = 1; ad1_cs = 1;
    cpu_addr = 15'h7FFC; ad0_addr = 16'hFFFC; ad1_addr = 16'h0000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      lat_cfg = $urandom_range(0, 4);
      a_v[0] = {1'b0, cpu_addr}; c_v[0] = cpu_cs; k_v[0] = cpu_ok; d_v[0] = cpu_data;
      a_v[1] = ad0_addr;         c_v[1] = ad0_cs; k_v[1] = ad0_ok; d_v[1] = ad0_data;
      a_v[2] = ad1_addr;         c_v[2] = ad1_cs; k_v[2] = ad1_ok; d_v[2] = ad1_data;
      for (int c = 0; c < 3; c++) begin
        if (k_v[c] === 1'b1) begin
          ea = ofs_a[c] + 18'(a_v[c]);
          checks++;
          if (d_v[c] !== mem_f(ea)) begin
            failures++; $display("FAIL rnd_data client=%0d addr=%h got=%h exp=%h", c, a_v[c], d_v[c], mem_f(ea));
          end
        end
        if (pk[c] && pc[c] && c_v[c] && a_v[c] == pa[c]) begin
          checks++;
          if (k_v[c] !== 1'b1) begin
            failures++; $display("FAIL rnd_hit_lost client=%0d addr=%h got=%b exp=1", c, a_v[c], k_v[c]);
          end
        end
        if (c_v[c] && k_v[c] !== 1'b1) stall[c]++; else stall[c] = 0;
        if (stall[c] > max_stall[c]) max_stall[c] = stall[c];
        pa[c] = a_v[c]; pc[c] = c_v[c]; pk[c] = (k_v[c] === 1'b1);
      end
      if ($urandom_range(0, 15) == 0) cpu_addr = 15'h7FFC + 15'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) ad0_addr = 16'hFFFC + 16'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) ad1_addr = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) cpu_cs = ~cpu_cs;
      if ($urandom_range(0, 19) == 0) ad0_cs = ~ad0_cs;
      if ($urandom_range(0, 19) == 0) ad1_cs = ~ad1_cs;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (max_stall[c] > 100) begin
        failures++; $display("FAIL rnd_starve client=%0d got=%0d cycles exp<=100", c, max_stall[c]);
      end
    end
    checks++;
    if (gap_err != g0) begin
      failures++; $display("FAIL rnd_gap got=%0d exp=%0d", gap_err, g0);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_basic();
    test_adpcm_pair();
    test_cpu_preempt();
    test_midfetch();
    test_reset_wait();
`ifdef JTDD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
